adv7513_video_timing: RTL and testbench

//  Generates the parallel video bus (24-bit RGB, HS, VS, DE) for the ADV7513 HDMI transmitter.

---
 rtl/adv7513_video_timing_if.sv | 31 +++
 rtl/adv7513_video_timing.sv | 188 ++++++++++++++++++
 tb/tb_adv7513_video_timing.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adv7513_video_timing_if.sv
// Parallel video bus plus upstream pixel req/valid handshake for the ADV7513 timing generator.
// master = timing generator side, slave = frame source / transmitter side.
interface adv7513_video_timing_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_req;
   logic [23:0] vid_data;
   logic        vid_hs;
   logic        vid_vs;
   logic        vid_de;

   modport master (
      input  pix_data,
      input  pix_valid,
      output pix_req,
      output vid_data,
      output vid_hs,
      output vid_vs,
      output vid_de
   );

   modport slave (
      output pix_data,
      output pix_valid,
      input  pix_req,
      input  vid_data,
      input  vid_hs,
      input  vid_vs,
      input  vid_de
   );
endinterface

// File: rtl/adv7513_video_timing.sv
// ADV7513 parallel video timing generator with req/valid pixel pull and frame-aligned start/stop.
// Optional colour-bar test pattern generator enabled by defining ADV7513_TPG_EN.
module adv7513_video_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 12
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          tpg_sel,
   adv7513_video_timing_if.master        vid_bus,
   output logic                          frame_start,
   output logic                          underflow,
   output logic                          busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             run;
   logic             active;
   logic             hs_on;
   logic             vs_on;
   logic             frame_end;
   logic             frame_boundary;
   logic             tpg_on;
   logic [23:0]      bar_rgb;
   logic [23:0]      next_data;

   assign run            = (state == S_RUN);
   assign busy           = run;
   assign active         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_on          = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_on          = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign frame_end      = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign frame_boundary = ((state == S_IDLE) && enable) || frame_end;

   // enable only matters in IDLE and on the last pixel of a frame, so frames are never cut short
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (enable) state <= S_RUN;
            end
            S_RUN: begin
               if (h_cnt == H_LAST) begin
                  h_cnt <= '0;
                  if (v_cnt == V_LAST) begin
                     v_cnt <= '0;
                     if (!enable) state <= S_IDLE;
                  end else begin
                     v_cnt <= v_cnt + 1'b1;
                  end
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               h_cnt <= '0;
               v_cnt <= '0;
            end
         endcase
      end
   end

`ifdef ADV7513_TPG_EN
   localparam int               BW    = H_ACTIVE / 8;
   localparam logic [CNT_W-1:0] BW_M1 = CNT_W'(BW - 1);

   logic             tpg_mode;
   logic [CNT_W-1:0] bar_pix;
   logic [2:0]       bar_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tpg_mode <= 1'b0;
      end else if (frame_boundary) begin
         tpg_mode <= tpg_sel;
      end
   end

   // Bar index tracks h_cnt with a width counter; the last bar absorbs any remainder pixels
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else if (!run || (h_cnt == H_LAST)) begin
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else if (h_cnt < H_ACT) begin
         if (bar_pix == BW_M1) begin
            if (bar_idx != 3'd7) begin
               bar_pix <= '0;
               bar_idx <= bar_idx + 3'd1;
            end
         end else begin
            bar_pix <= bar_pix + 1'b1;
         end
      end
   end

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   assign tpg_on = tpg_mode;
`else
   logic unused_tpg_sel;

   assign unused_tpg_sel = tpg_sel;
   assign tpg_on         = 1'b0;
   assign bar_rgb        = 24'h000000;
`endif

   assign vid_bus.pix_req = run && active && !tpg_on;

   always_comb begin
      next_data = 24'h000000;
      if (run && active) begin
         if (tpg_on) begin
            next_data = bar_rgb;
         end else if (vid_bus.pix_valid) begin
            next_data = vid_bus.pix_data;
         end
      end
   end

   // Output stage: every video output lags the counters by exactly one pixel clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vid_bus.vid_data <= 24'h000000;
         vid_bus.vid_de   <= 1'b0;
         vid_bus.vid_hs   <= ~HS_POL;
         vid_bus.vid_vs   <= ~VS_POL;
         frame_start      <= 1'b0;
         underflow        <= 1'b0;
      end else begin
         vid_bus.vid_data <= next_data;
         vid_bus.vid_de   <= run && active;
         vid_bus.vid_hs   <= (run && hs_on) ? HS_POL : ~HS_POL;
         vid_bus.vid_vs   <= (run && vs_on) ? VS_POL : ~VS_POL;
         frame_start      <= run && (h_cnt == '0) && (v_cnt == '0);
         if (vid_bus.pix_req && !vid_bus.pix_valid) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adv7513_video_timing.sv
// Randomized self-checking bench for adv7513_video_timing using a frame-position reference model.
// Define ADV7513_TPG_EN to also exercise the colour-bar generator.
module tb_adv7513_video_timing;

   localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
   localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int FRAME = HT * VT;
   localparam int BW = HA / 8;
`ifdef ADV7513_TPG_EN
   localparam bit TPG_BUILD = 1'b1;
`else
   localparam bit TPG_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic tpg_sel = 1'b0;
   logic frame_start;
   logic underflow;
   logic busy;

   adv7513_video_timing_if vbus();

   adv7513_video_timing #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
      .HS_POL   (1'b0), .VS_POL (1'b0), .CNT_W (12)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .tpg_sel     (tpg_sel),
      .vid_bus     (vbus),
      .frame_start (frame_start),
      .underflow   (underflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: running flag plus linear position within the 98-pixel frame
   bit mRun = 1'b0;
   bit mTpg = 1'b0;
   bit mUnder = 1'b0;
   int mPos = 0;
   logic [23:0] barRgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_de"},      24'(vbus.vid_de),   24'h0);
      checkOutput({tag, "_hs"},      24'(vbus.vid_hs),   24'h1);
      checkOutput({tag, "_vs"},      24'(vbus.vid_vs),   24'h1);
      checkOutput({tag, "_data"},    vbus.vid_data,      24'h0);
      checkOutput({tag, "_fs"},      24'(frame_start),   24'h0);
      checkOutput({tag, "_under"},   24'(underflow),     24'h0);
      checkOutput({tag, "_busy"},    24'(busy),          24'h0);
      checkOutput({tag, "_pix_req"}, 24'(vbus.pix_req),  24'h0);
   endtask

   task automatic applyStimulus(input bit en, input bit valid, input logic [23:0] data, input bit tsel);
      int h, v, bar;
      bit act, tpgNow, expHs, expVs, expFs;
      logic [23:0] expData;
      enable = en;
      vbus.pix_valid = valid;
      vbus.pix_data = data;
      tpg_sel = tsel;
      #1;
      h = mPos % HT;
      v = mPos / HT;
      act = mRun && (h < HA) && (v < VA);
      tpgNow = TPG_BUILD && mTpg;
      checkOutput("pix_req", 24'(vbus.pix_req), 24'(act && !tpgNow));
      checkOutput("busy", 24'(busy), 24'(mRun));
      expHs = !(mRun && (h >= HA + HF) && (h < HA + HF + HSY));
      expVs = !(mRun && (v >= VA + VF) && (v < VA + VF + VSY));
      expFs = mRun && (mPos == 0);
      bar = (h / BW > 7) ? 7 : h / BW;
      if (!act) expData = 24'h0;
      else if (tpgNow) expData = barRgb[bar];
      else expData = valid ? data : 24'h0;
      if (act && !tpgNow && !valid) mUnder = 1'b1;
      if (!mRun) begin
         if (en) begin
            mRun = 1'b1;
            mPos = 0;
            mTpg = tsel;
         end
      end else if (mPos == FRAME - 1) begin
         mPos = 0;
         mTpg = tsel;
         if (!en) mRun = 1'b0;
      end else begin
         mPos++;
      end
      @(posedge clk);
      #1;
      checkOutput("vid_de", 24'(vbus.vid_de), 24'(act));
      checkOutput("vid_hs", 24'(vbus.vid_hs), 24'(expHs));
      checkOutput("vid_vs", 24'(vbus.vid_vs), 24'(expVs));
      checkOutput("vid_data", vbus.vid_data, expData);
      checkOutput("frame_start", 24'(frame_start), 24'(expFs));
      checkOutput("underflow", 24'(underflow), 24'(mUnder));
   endtask

   task automatic resetModel();
      mRun = 1'b0;
      mTpg = 1'b0;
      mUnder = 1'b0;
      mPos = 0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vbus.pix_valid = 1'b0;
      vbus.pix_data = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset_hold");
      @(negedge clk);
      reset = 1'b1;
      resetModel();

      // Idle with enable low: outputs stay blank
      repeat (5) applyStimulus(1'b0, 1'b1, 24'($urandom), 1'b0);

      // Two frames with pixel data equal to the column index
      for (int i = 0; i < 2 * FRAME; i++)
         applyStimulus(1'b1, 1'b1, 24'(mPos % HT), 1'b0);

      // One missing pixel at line 1 pixel 3, underflow must stick
      for (int i = 0; i < FRAME + 2; i++)
         applyStimulus(1'b1, !(mRun && mPos == HT + 3), 24'(mPos % HT), 1'b0);

      // Drop enable from line 2 onwards: the frame still completes before going idle
      for (int i = 0; i < 2 * FRAME && mPos != 2 * HT; i++)
         applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
      for (int i = 0; i < 2 * FRAME && mRun; i++)
         applyStimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
      checkOutput("busy_after_stop", 24'(busy), 24'h0);
      repeat (4) applyStimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
      repeat (6) applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0);

      // Asynchronous reset at line 1 pixel 5, between clock edges
      for (int i = 0; i < 2 * FRAME && mPos != HT + 5; i++)
         applyStimulus(1'b1, 1'b1, 24'($urandom | 24'h1), 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("async_reset");
      resetModel();
      @(negedge clk);
      reset = 1'b1;

`ifdef ADV7513_TPG_EN
      // Colour bars: two frames with tpg_sel held high
      for (int i = 0; i < 2 * FRAME + 1; i++)
         applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b1);
`endif

      // Randomized traffic: occasional enable drops, missing pixels and tpg_sel toggles
      for (int i = 0; i < 8 * FRAME; i++)
         applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 39) != 0,
                       24'($urandom), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
